// File: rtl/regfile_ecall_unit.sv
// ----------------------------------------------------------------------------
// regfile_ecall_unit
//   Integer register file for the single-cycle RISC-V core. It has two
//   combinational read ports and one synchronous write port. It also contains
//   the environment-call service engine. That engine performs print, read,
//   exit and PC-change services through valid/ready handshakes to the I/O
//   block, and it stalls the core while a service is outstanding.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   ecall                      current instruction is ECALL
//   rs1, rs2 / read_data1,2    combinational read ports (x0 reads 0)
//   rd, write_data, reg_write  write port (x0 writes discarded)
//   io_in_data/valid/ready     input word handshake (engine is the sink)
//   io_out_data/valid/ready    output word handshake (engine is the source)
//   stall                      core holds PC and suppresses commit
//   halted                     program has exited (sticky until reset)
//   pc_change                  one-cycle PC redirect request
//   led_out                    [7] input just received, [0] halted
// ----------------------------------------------------------------------------

// One read port. Forwarding is only applied for writes that the engine
// actually accepts, so a write issued in an ecall cycle is never visible.
module regfile_ecall_rdport #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data
);
    logic fwd;

    // wr_en already excludes rd==0.
    assign fwd  = (BYPASS != 0) && wr_en && (wr_addr == addr);
    assign data = (addr == '0) ? '0 : (fwd ? wr_data : reg_data);
endmodule

module regfile_ecall_unit #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1,
    parameter int A0_IDX = 10,
    parameter int A7_IDX = 17
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ecall,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic            reg_write,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] io_in_data,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    output logic [XLEN-1:0] io_out_data,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic            stall,
    output logic            halted,
    output logic            pc_change,
    output logic [7:0]      led_out
);
    localparam int NREG = 2 ** AW;
    localparam int NRP  = 2;

    localparam logic [AW-1:0]   A0_ADDR = AW'(A0_IDX);
    localparam logic [AW-1:0]   A7_ADDR = AW'(A7_IDX);

    localparam logic [XLEN-1:0] SVC_PRINT = XLEN'(1);
    localparam logic [XLEN-1:0] SVC_READ  = XLEN'(5);
    localparam logic [XLEN-1:0] SVC_EXIT  = XLEN'(10);
    localparam logic [XLEN-1:0] SVC_PCCH  = XLEN'(11);

    typedef enum logic [2:0] {
        IDLE,
        OUT_WAIT,
        IN_WAIT,
        DONE,
        HALT
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] regs [NREG];

    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            halted_q, halted_d;
    logic            pc_change_q, pc_change_d;
    logic            led7_q, led7_d;

    logic            wr_ok;       // state allows a normal register write
    logic            a0_load;     // input service completes this edge
    logic            wr_accept;
    logic [XLEN-1:0] a7_val;

    // The service code is decoded from the architectural a7. Forwarding is
    // not needed here because writes are ignored in any ecall cycle.
    assign a7_val    = regs[A7_ADDR];
    assign wr_accept = wr_ok && reg_write && (rd != '0);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [NRP-1:0][AW-1:0]   rp_addr;
    logic [NRP-1:0][XLEN-1:0] rp_data;

    assign rp_addr = {rs2, rs1};

    for (genvar g = 0; g < NRP; g++) begin : g_rp
        regfile_ecall_rdport #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rp (
            .addr     (rp_addr[g]),
            .reg_data (regs[rp_addr[g]]),
            .wr_en    (wr_accept),
            .wr_addr  (rd),
            .wr_data  (write_data),
            .data     (rp_data[g])
        );
    end

    assign read_data1 = rp_data[0];
    assign read_data2 = rp_data[1];

    // ------------------------------------------------------------------
    // Service FSM: next state, next registered outputs, stall
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        halted_d    = halted_q;
        pc_change_d = 1'b0;
        led7_d      = led7_q;
        stall       = 1'b0;
        wr_ok       = 1'b0;
        a0_load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ecall) begin
                    unique case (a7_val)
                        SVC_PRINT: begin
                            out_data_d  = regs[A0_ADDR];
                            out_valid_d = 1'b1;
                            stall       = 1'b1;
                            state_d     = OUT_WAIT;
                        end
                        SVC_READ: begin
                            in_ready_d = 1'b1;
                            stall      = 1'b1;
                            state_d    = IN_WAIT;
                        end
                        SVC_EXIT: begin
                            halted_d = 1'b1;
                            stall    = 1'b1;
                            state_d  = HALT;
                        end
                        SVC_PCCH: pc_change_d = 1'b1;
                        default: ;
                    endcase
                end else begin
                    wr_ok = 1'b1;
                end
            end
            OUT_WAIT: begin
                stall = 1'b1;
                if (out_valid_q && io_out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = DONE;
                end
            end
            IN_WAIT: begin
                stall = 1'b1;
                if (io_in_valid) begin
                    a0_load    = 1'b1;
                    in_ready_d = 1'b0;
                    led7_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // The core retires the ECALL here, so a new ecall is not decoded.
                wr_ok   = 1'b1;
                led7_d  = 1'b0;
                state_d = IDLE;
            end
            HALT: stall = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
            pc_change_q <= 1'b0;
            led7_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
            pc_change_q <= pc_change_d;
            led7_q      <= led7_d;
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_accept) begin
            regs[rd] <= write_data;
        end else if (a0_load && (A0_ADDR != '0)) begin
            regs[A0_ADDR] <= io_in_data;
        end
    end

    assign io_out_data  = out_data_q;
    assign io_out_valid = out_valid_q;
    assign io_in_ready  = in_ready_q;
    assign halted       = halted_q;
    assign pc_change    = pc_change_q;
    assign led_out      = {led7_q, 6'b000000, halted_q};
endmodule

// File: doc/regfile_ecall_unit.md
Name: regfile_ecall_unit

Overview:
Parametrised integer register file with an integrated environment-call service engine for the single-cycle RISC-V core. It provides 2 asynchronous read ports and 1 synchronous write port. Ecalls are serviced through a small FSM with valid/ready handshakes to the I/O block, and the core is stalled while a service is pending. Halt and PC-redirect requests are reported to the top level and LEDs.

Parameters:
XLEN, 32, data width of every register and I/O word
AW, 5, register address width; NREG = 2**AW registers
BYPASS, 1, 1 = same-cycle write-to-read forwarding on both read ports; 0 = none
A0_IDX, 10, register index used as ecall argument/result
A7_IDX, 17, register index holding the ecall service code

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ecall  in  1  current instruction is ECALL
rs1  in  AW  read address 1
rs2  in  AW  read address 2
rd  in  AW  write address
write_data  in  XLEN  write data
reg_write  in  1  write enable
read_data1  out  XLEN  rs1 data
read_data2  out  XLEN  rs2 data
io_in_data  in  XLEN  input word from switches
io_in_valid  in  1  io_in_data valid
io_in_ready  out  1  engine accepting input
io_out_data  out  XLEN  word to display
io_out_valid  out  1  io_out_data valid
io_out_ready  in  1  display accepted word
stall  out  1  core must hold PC and not commit
halted  out  1  program exited
pc_change  out  1  one-cycle PC redirect request
led_out  out  8  status LEDs

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge, with priority over everything else, including mid-handshake.
- Reset values: all registers 0, state IDLE, io_out_valid 0, io_out_data 0, io_in_ready 0, halted 0, pc_change 0, led_out 8'h00.
- Reads are combinational. Address 0 always reads 0.
- BYPASS=1: if a write is accepted this cycle and rd==rsN with rd!=0, then read_dataN = write_data.
- Writes with rd==0 are discarded.
- Normal writes are accepted only in IDLE (when ecall=0) and in DONE.
- FSM states: IDLE, OUT_WAIT, IN_WAIT, DONE, HALT.
- IDLE with ecall=1 decodes the full XLEN value of reg[A7_IDX]:
  - 1: io_out_data <= reg[A0_IDX], io_out_valid <= 1, next state OUT_WAIT.
  - 5: io_in_ready <= 1, next state IN_WAIT.
  - 10: halted <= 1, led_out[0] <= 1, next state HALT.
  - 11: pc_change <= 1 for exactly one cycle, stay in IDLE.
  - Any other code: no-op, stay in IDLE.
  - reg_write is ignored in any ecall cycle.
- OUT_WAIT: io_out_valid and io_out_data are held stable until io_out_valid && io_out_ready. On that edge, clear io_out_valid and go to DONE.
- IN_WAIT: io_in_ready is held at 1. On an edge where io_in_valid=1: reg[A0_IDX] <= io_in_data, io_in_ready <= 0, led_out[7] <= 1, go to DONE.
- DONE: lasts one cycle. stall=0, ecall is ignored (the core retires the ECALL this cycle), led_out[7] is cleared at the exit edge, next state IDLE.
- HALT: absorbing. stall=1, all writes and ecalls are ignored, halted and led_out[0] stay at 1 until reset.
- stall is combinational. It is 1 when:
  - state is OUT_WAIT, IN_WAIT or HALT, or
  - state is IDLE, ecall=1, and reg[A7_IDX] is 1, 5 or 10.
- led_out[6:1] are always 0.
- Latency:
  - print: stall for 1 + N cycles, where N is the number of cycles waiting for io_out_ready (minimum 1); DONE follows.
  - input: same structure, with N the number of cycles waiting for io_in_valid.
- A handshake completing on the same edge the wait state is entered is not possible; completion is checked only in the wait state.

Test Plan:
- Reset, then write x5=32'hDEADBEEF and x0=32'h1; read rs1=5, rs2=0 -> read_data1=DEADBEEF, read_data2=0. In the write cycle with BYPASS=1 and rs1=5 -> read_data1=DEADBEEF.
- a7=1, a0=32'h0000002A, ecall=1, io_out_ready low for 3 cycles then high -> stall=1 for 5 cycles, io_out_data=2A held stable, io_out_valid drops after the ready edge, then DONE with stall=0, then IDLE.
- a7=5, ecall=1, io_in_valid rises after 2 cycles with data 32'h00000077 -> a0=77, led_out[7]=1 for exactly 1 cycle (DONE), stall=0 in DONE.
- a7=11, ecall=1 -> pc_change=1 for exactly one cycle, stall=0 throughout. a7=99 -> no effect on any output.
- a7=10, ecall=1 -> halted=1, led_out=8'h01, stall=1. Subsequent reg_write and ecall are ignored. Assert reset -> all outputs return to reset values.
- Assert reset while in OUT_WAIT and while in IN_WAIT -> next cycle is IDLE, io_out_valid=0, io_in_ready=0, a0 reads 0.
